// File: rtl/delay_line_ctrl_if.sv
// delay_line_ctrl_if: stream-in, stream-out and block-RAM port signals of the
// delay line controller. The controller connects through the slave modport;
// the environment (source, sink and RAM) drives the master modport.
interface delay_line_ctrl_if #(
  parameter int W = 16,
  parameter int L = 1024
);
  localparam int AW = $clog2(L);

  // input sample stream
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] delay;

  // output sample stream
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  // attached block RAM (synchronous read, one clk latency)
  logic [AW-1:0] ram_rd_addr;
  logic [W-1:0]  ram_rd_data;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_wr_addr;
  logic [W-1:0]  ram_wr_data;

  modport master (
    output in_valid, in_data, delay, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, ram_rd_addr,
    input  ram_wr_ena, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  in_valid, in_data, delay, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, ram_rd_addr,
    output ram_wr_ena, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sample delay line built around an external block RAM.
// Each accepted sample walks IDLE -> READ -> WAIT -> WRITE -> IDLE: the delayed
// sample is read from (wr_ptr - delay) mod L, the new sample is written at
// wr_ptr, and the result is held on the output until the sink takes it.
// A fill counter masks RAM locations not yet written since reset, so the
// RAM never needs clearing.
// Optional feature: define ECHO_FEEDBACK_EN to store and output the saturated
// echo sum in + (delayed >>> FB_SHIFT) instead of the plain delay.
module delay_line_ctrl #(
  parameter int W        = 16,
  parameter int L        = 1024,
  parameter int FB_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  delay_line_ctrl_if.slave bus
);
  localparam int AW = $clog2(L);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(L);

  // elaboration-time parameter sanity
  if ((L < 2) || ((L & (L - 1)) != 0)) begin : g_bad_depth
    $error("delay_line_ctrl: L must be a power of two >= 2");
  end
  if ((FB_SHIFT < 0) || (FB_SHIFT >= W)) begin : g_bad_fb_shift
    $error("delay_line_ctrl: FB_SHIFT must lie in [0, W-1]");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;

  logic [AW-1:0] wr_ptr_r;
  logic [FW-1:0] fill_r;
  logic [W-1:0]  in_data_r;
  logic [AW-1:0] delay_r;
  logic [W-1:0]  result_r;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [AW-1:0] ram_rd_addr_r;
  logic          ram_wr_ena_r;
  logic [AW-1:0] ram_wr_addr_r;
  logic [W-1:0]  ram_wr_data_r;

  logic          in_ready_s;
  logic          accept_s;
  logic [W-1:0]  delayed_s;
  logic [W-1:0]  wr_data_s;
  logic [W-1:0]  result_s;

`ifdef ECHO_FEEDBACK_EN
  // Signed add of two W-bit values, clipped to the W-bit two's complement range.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) begin
      sat_add = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat_add = sum[W-1:0];
    end
  endfunction
`endif

  // A new sample is taken only when idle and the output register is free
  // (or being emptied in this same cycle).
  assign in_ready_s = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.ram_rd_addr = ram_rd_addr_r;
  assign bus.ram_wr_ena  = ram_wr_ena_r;
  assign bus.ram_wr_addr = ram_wr_addr_r;
  assign bus.ram_wr_data = ram_wr_data_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: one clk per state once a sample is accepted
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ:    state_s = WAIT;
      WAIT:    state_s = WRITE;
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Latch sample and delay on acceptance; the read address is registered so
  // it is stable on the RAM port for the whole READ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data_r     <= {W{1'b0}};
      delay_r       <= {AW{1'b0}};
      ram_rd_addr_r <= {AW{1'b0}};
    end else if (accept_s) begin
      in_data_r     <= bus.in_data;
      delay_r       <= bus.delay;
      ram_rd_addr_r <= wr_ptr_r - bus.delay;
    end
  end

  // Delayed value: zero delay echoes the current sample, locations not yet
  // written since reset read as silence, otherwise take the RAM data.
  always_comb begin
    delayed_s = {W{1'b0}};
    if (delay_r == {AW{1'b0}}) begin
      delayed_s = in_data_r;
    end else if ({1'b0, delay_r} > fill_r) begin
      delayed_s = {W{1'b0}};
    end else begin
      delayed_s = bus.ram_rd_data;
    end
  end

`ifdef ECHO_FEEDBACK_EN
  logic signed [W-1:0] fb_term_s;
  assign fb_term_s = $signed(delayed_s) >>> FB_SHIFT;
  assign wr_data_s = sat_add(in_data_r, fb_term_s);
  assign result_s  = wr_data_s;
`else
  assign wr_data_s = in_data_r;
  assign result_s  = delayed_s;
`endif

  // Capture the RAM result while it is valid (WAIT) and set up the single
  // write cycle; ram_wr_ena is high exactly during WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_ena_r  <= 1'b0;
      ram_wr_addr_r <= {AW{1'b0}};
      ram_wr_data_r <= {W{1'b0}};
      result_r      <= {W{1'b0}};
    end else begin
      ram_wr_ena_r <= (state_r == WAIT);
      if (state_r == WAIT) begin
        ram_wr_addr_r <= wr_ptr_r;
        ram_wr_data_r <= wr_data_s;
        result_r      <= result_s;
      end
    end
  end

  // Advance the write pointer (mod L) and the saturating fill count per write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      fill_r   <= {FW{1'b0}};
    end else if (state_r == WRITE) begin
      wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + {{(FW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Output register: loaded at the end of WRITE, held until the sink takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
    end else if (state_r == WRITE) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_r;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: table vectors, hand-written corner sequences and random
// transactions checked against a sample-history model of the delay line.
module tb_delay_line_ctrl;
  localparam int W  = 16;
  localparam int L  = 16;
  localparam int AW = 4;
  localparam int FB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_line_ctrl_if #(.W(W), .L(L)) bus ();

  delay_line_ctrl #(.W(W), .L(L), .FB_SHIFT(FB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // attached block RAM: synchronous read, data one clk after address
  logic [W-1:0] mem [L];
  always @(posedge clk) begin
    if (bus.ram_wr_ena) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  // write and output-handshake monitors
  int wr_cnt = 0;
  int hs_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  always @(posedge clk) begin
    if (!rst && bus.ram_wr_ena) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.ram_wr_addr;
    end
    if (!rst && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
  end

  int tests = 0;
  int fails = 0;
  int last_lat = 0;

  // model: every value stored since reset, oldest first
  logic [W-1:0] hist[$];

  function automatic logic [W-1:0] model_step(input logic [W-1:0] x, input int d);
    logic [W-1:0] dl;
    logic [W-1:0] res;
    int s;
    if (d == 0) dl = x;
    else if (d > hist.size()) dl = '0;
    else dl = hist[hist.size() - d];
`ifdef ECHO_FEEDBACK_EN
    s = int'($signed(x)) + (int'($signed(dl)) >>> FB);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    res = s[W-1:0];
    hist.push_back(res);
`else
    s = 0;
    res = dl;
    hist.push_back(x);
`endif
    return res + W'(s - s);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.delay = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"},  bus.out_data, 16'h0000);
    check({tag, "_wr_ena"},    bus.ram_wr_ena, 1'b0);
    check({tag, "_rd_addr"},   bus.ram_rd_addr, 4'h0);
    check({tag, "_wr_addr"},   bus.ram_wr_addr, 4'h0);
    check({tag, "_wr_data"},   bus.ram_wr_data, 16'h0000);
  endtask

  // offer one sample and return #1 after the accepting edge; the delay input
  // is then scrambled to show it only matters at acceptance
  task automatic push(input logic [W-1:0] x, input logic [AW-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = x;
    bus.delay = d;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) timeout("accept");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.delay = AW'($urandom);
    bus.in_data = W'($urandom);
  endtask

  // wait for out_valid, compare, optionally stall the sink, then take it
  task automatic pull(input logic [W-1:0] exp, input string nm, input int stall);
    int n;
    n = 0;
    bus.out_ready = (stall == 0) ? 1'b1 : 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 40);
    last_lat = n;
    if (bus.out_valid !== 1'b1) begin
      timeout(nm);
    end else begin
      check(nm, bus.out_data, exp);
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        check({nm, "_held"}, {bus.out_valid, bus.out_data}, {1'b1, exp});
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [W-1:0]  din;
    logic [AW-1:0] dly;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] x;
    logic [AW-1:0] d;
    int wc;
    int h0;

`ifdef ECHO_FEEDBACK_EN
    tbl.push_back('{16'h7000, 4'd1, 16'h7000});
    tbl.push_back('{16'h7000, 4'd1, 16'h7FFF});
    tbl.push_back('{16'h8000, 4'd0, 16'h8000});
    tbl.push_back('{16'h8000, 4'd1, 16'h8000});
`else
    tbl.push_back('{16'h0001, 4'd2,  16'h0000});
    tbl.push_back('{16'h0002, 4'd2,  16'h0000});
    tbl.push_back('{16'h0003, 4'd2,  16'h0001});
    tbl.push_back('{16'h0004, 4'd2,  16'h0002});
    tbl.push_back('{16'h0005, 4'd2,  16'h0003});
    tbl.push_back('{16'h1234, 4'd0,  16'h1234});
    tbl.push_back('{16'hBEEF, 4'd3,  16'h0004});
    tbl.push_back('{16'h0007, 4'd15, 16'h0000});
    tbl.push_back('{16'h00AA, 4'd7,  16'h0002});
    tbl.push_back('{16'h8000, 4'd9,  16'h0001});
    tbl.push_back('{16'h0055, 4'd11, 16'h0000});
`endif

    // reset state
    do_reset();
    check_reset_state("reset");
    check("reset_in_ready", bus.in_ready, 1'b1);

    // zero delay: 4 clk latency, a single write at address 0
    wc = wr_cnt;
    e = model_step(16'h1234, 0);
    push(16'h1234, 4'd0);
    pull(e, "dly0_data", 0);
    check("dly0_latency", last_lat, 4);
    check("dly0_writes", wr_cnt - wc, 1);
    check("dly0_wr_addr", last_wr_addr, 4'h0);

    // table vectors from a fresh reset
    do_reset();
    foreach (tbl[i]) begin
      e = model_step(tbl[i].din, tbl[i].dly);
      push(tbl[i].din, tbl[i].dly);
      pull(tbl[i].exp, $sformatf("vec%0d", i), 0);
    end

    // backpressure: sink stalls for 10 clk while a new sample is offered
    e = model_step(16'h0321, 1);
    bus.out_ready = 1'b0;
    push(16'h0321, 4'd1);
    wc = 0;
    while (bus.out_valid !== 1'b1 && wc < 40) begin
      @(negedge clk);
      wc++;
    end
    check("bp_first", {bus.out_valid, bus.out_data}, {1'b1, e});
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0456;
    bus.delay = 4'd2;
    h0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== e) h0++;
    end
    check("bp_hold_bad_cycles", h0, 0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", {bus.in_ready, bus.out_valid}, 2'b00);
    e = model_step(16'h0456, 2);
    pull(e, "bp_second", 0);

    // wrap: L+3 samples at delay 1
    do_reset();
    h0 = hs_cnt;
    for (int k = 1; k <= L + 3; k++) begin
      x = W'(16'h0100 + k);
      e = model_step(x, 1);
      push(x, 4'd1);
      pull(e, $sformatf("wrap%0d", k), 0);
      if (k == L + 1) check("wrap_sample_L", bus.out_data, 16'h0100 + L);
    end
    check("wrap_outputs", hs_cnt - h0, L + 3);
    check("wrap_last_addr", last_wr_addr, 4'd2);
    e = model_step(16'h0999, 1);
    push(16'h0999, 4'd1);
    pull(e, "wrap_next", 0);
    check("wrap_ptr", last_wr_addr, 4'd3);

    // reset during WAIT: no write, then RAM contents masked by fill count
    push(16'h5555, 4'd4);
    @(posedge clk);
    #1;
    wc = wr_cnt;
    rst = 1'b1;
    #1;
    check_reset_state("rstmid");
    repeat (3) @(negedge clk);
    check("rstmid_no_write", wr_cnt - wc, 0);
    rst = 1'b0;
    hist.delete();
    for (int k = 1; k <= 5; k++) begin
      x = W'(16'h0A00 + k);
      e = model_step(x, 4);
      push(x, 4'd4);
      pull(e, $sformatf("rstmid_out%0d", k), 0);
    end

    // random traffic with random sink stalls
    for (int i = 0; i < 200; i++) begin
      x = W'($urandom);
      d = ($urandom_range(0, 4) == 0) ? 4'd0 : AW'($urandom);
      e = model_step(x, int'(d));
      push(x, d);
      pull(e, "rand", $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
